// File: rtl/seq_gen_1001.sv
// ============================================================================
//  Module   : seq_gen_1001
//  Purpose  : Serial pattern transmitter, MSB-first, with repeat count and
//             inter-frame gap. Define SEQ_GEN_PARITY_EN to append an even
//             parity bit after each frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_gen_1001 #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   output logic             op,
   output logic             op_valid,
   output logic             busy,
   output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
   localparam int C_FRAME = PAT_W + 1;
`else
   localparam int C_FRAME = PAT_W;
`endif
   localparam int C_IDX_W = $clog2(C_FRAME) + 1;
   localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(C_FRAME - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [PAT_W-1:0]   r_pat;
   logic [PAT_W-1:0]   r_shift;
   logic [CNT_W-1:0]   r_reps;
   logic [GAP_W-1:0]   r_gap;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [C_IDX_W-1:0] r_bit_cnt;
`ifdef SEQ_GEN_PARITY_EN
   localparam logic [C_IDX_W-1:0] C_PAT_LAST = C_IDX_W'(PAT_W - 1);
   logic               r_par;
`endif

   // Outputs always describe the current cycle; every branch sets them for the next one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pat     <= '0;
         r_shift   <= '0;
         r_reps    <= '0;
         r_gap     <= '0;
         r_gap_cnt <= '0;
         r_bit_cnt <= '0;
`ifdef SEQ_GEN_PARITY_EN
         r_par     <= 1'b0;
`endif
         op        <= 1'b0;
         op_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_pat     <= pattern;
                  r_reps    <= (reps == '0) ? CNT_W'(1) : reps;
                  r_gap     <= gap;
`ifdef SEQ_GEN_PARITY_EN
                  r_par     <= ^pattern;
`endif
                  r_shift   <= {pattern[PAT_W-2:0], 1'b0};
                  r_bit_cnt <= '0;
                  op        <= pattern[PAT_W-1];
                  op_valid  <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= SHIFT;
               end else begin
                  op       <= 1'b0;
                  op_valid <= 1'b0;
                  busy     <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            SHIFT: begin
               if (r_bit_cnt != C_LAST) begin
                  r_bit_cnt <= r_bit_cnt + C_IDX_W'(1);
                  r_shift   <= {r_shift[PAT_W-2:0], 1'b0};
`ifdef SEQ_GEN_PARITY_EN
                  op        <= (r_bit_cnt == C_PAT_LAST) ? r_par : r_shift[PAT_W-1];
`else
                  op        <= r_shift[PAT_W-1];
`endif
               end else if (r_reps > CNT_W'(1)) begin
                  r_reps <= r_reps - CNT_W'(1);
                  if (r_gap == '0) begin
                     r_bit_cnt <= '0;
                     r_shift   <= {r_pat[PAT_W-2:0], 1'b0};
                     op        <= r_pat[PAT_W-1];
                  end else begin
                     r_gap_cnt <= r_gap;
                     op        <= 1'b0;
                     op_valid  <= 1'b0;
                     r_state   <= GAP;
                  end
               end else begin
                  op       <= 1'b0;
                  op_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= DONE;
               end
            end
            GAP: begin
               // r_gap_cnt counts the gap cycles still to be shown, including this one.
               if (r_gap_cnt == GAP_W'(1)) begin
                  r_bit_cnt <= '0;
                  r_shift   <= {r_pat[PAT_W-2:0], 1'b0};
                  op        <= r_pat[PAT_W-1];
                  op_valid  <= 1'b1;
                  r_state   <= SHIFT;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               op       <= 1'b0;
               op_valid <= 1'b0;
               busy     <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_1001.sv
// ============================================================================
//  Module   : tb_seq_gen_1001
//  Purpose  : Scoreboard bench for seq_gen_1001 (directed and random runs).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_gen_1001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] pattern = '0;
   logic [3:0] reps = '0;
   logic [3:0] gap = '0;
   logic       op, op_valid, busy, done;

   int tests = 0;
   int fails = 0;
   int det_count = 0;
   logic [3:0] det_hist = '0;

   // Each entry is one expected cycle: {busy, op_valid, op, done}.
   logic [3:0] exp_q[$];

   seq_gen_1001 #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .pattern  (pattern),
      .reps     (reps),
      .gap      (gap),
      .op       (op),
      .op_valid (op_valid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Reference: a transfer is reps_eff frames, gap idle cycles between frames, then a done cycle.
   task automatic push_expected(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
      int re;
      re = (r == 0) ? 1 : int'(r);
      for (int k = 0; k < re; k++) begin
         for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, 1'b1, p[i], 1'b0});
`ifdef SEQ_GEN_PARITY_EN
         exp_q.push_back({1'b1, 1'b1, ^p, 1'b0});
`endif
         if (k < re - 1)
            for (int j = 0; j < int'(g); j++) exp_q.push_back(4'b1000);
      end
      exp_q.push_back(4'b0001);
   endtask

   always @(negedge clk) begin
      logic [3:0] got;
      logic [3:0] e;
      got = {busy, op_valid, op, done};
      if (rst_n && (busy || op_valid || done)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output got=%b expected=<none>", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               fails++;
               $display("FAIL stream got=%b expected=%b (busy,valid,op,done)", got, e);
            end
         end
         if (op_valid) begin
            det_hist = {det_hist[2:0], op};
            if (det_hist == 4'b1001) det_count++;
         end
      end
      if (!op_valid && op) begin
         tests++;
         fails++;
         $display("FAIL op_not_zero got=%b expected=0", op);
      end
   end

   // Called just after a negedge; start is sampled at the next posedge.
   task automatic issue(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
      pattern = p;
      reps    = r;
      gap     = g;
      start   = 1'b1;
      push_expected(p, r, g);
      @(posedge clk);
      #1;
      start   = 1'b0;
      pattern = 4'($urandom);
      reps    = 4'($urandom);
      gap     = 4'($urandom);
   endtask

   // Returns at the negedge where done is high; optional ignored-start noise while busy.
   task automatic wait_done(input bit noise, input bit force_ones);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         if (done) seen = 1;
         else if (busy && noise && $urandom_range(0, 2) == 0) begin
            start   = 1'b1;
            pattern = force_ones ? 4'b1111 : 4'($urandom);
            reps    = 4'($urandom);
            gap     = 4'($urandom);
         end else start = 1'b0;
      end
      start = 1'b0;
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL done_timeout got=no_done expected=done within 400 cycles");
         exp_q.delete();
      end
   endtask

   task automatic check_drained(input string name);
      @(posedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s leftover got=%0d expected=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      bit saw_done;
      logic [3:0] rp, rr, rg;

      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({op, op_valid, busy, done} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_state got=%b expected=0000", {op, op_valid, busy, done});
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Single frame, then three back-to-back frames with an overlap detector count
      issue(4'b1001, 4'd1, 4'd0);
      wait_done(0, 0);
      check_drained("single");

      det_hist  = '0;
      det_count = 0;
      @(negedge clk);
      issue(4'b1001, 4'd3, 4'd0);
      wait_done(0, 0);
      check_drained("contig");
      tests++;
      if (det_count != 3) begin
         fails++;
         $display("FAIL detect_count got=%0d expected=3", det_count);
      end

      @(negedge clk);
      issue(4'b1001, 4'd2, 4'd2);
      wait_done(0, 0);
      check_drained("gap2");

      @(negedge clk);
      issue(4'b0110, 4'd0, 4'd0);
      wait_done(0, 0);
      check_drained("reps0");

      @(negedge clk);
      issue(4'b1001, 4'd1, 4'd0);
      wait_done(1, 1);
      check_drained("ignore_start");

      @(negedge clk);
      issue(4'b1011, 4'd2, 4'd0);
      wait_done(0, 0);
      check_drained("parity_case");

      // Start accepted in the DONE cycle
      @(negedge clk);
      issue(4'b1011, 4'd2, 4'd0);
      wait_done(0, 0);
      issue(4'b0101, 4'd3, 4'd1);
      wait_done(0, 0);
      check_drained("done_restart");

      // Reset asserted during the second bit
      @(negedge clk);
      issue(4'b1001, 4'd1, 4'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      @(negedge clk);
      tests++;
      if ({op, op_valid, busy, done} !== 4'b0000) begin
         fails++;
         $display("FAIL abort_state got=%b expected=0000", {op, op_valid, busy, done});
      end
      rst_n = 1'b1;
      saw_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) saw_done = 1;
      end
      tests++;
      if (saw_done) begin
         fails++;
         $display("FAIL abort_no_done got=activity expected=idle");
      end

      // Randomized transfers with ignored-start noise and occasional DONE restarts
      for (int t = 0; t < 40; t++) begin
         rp = 4'($urandom);
         rr = 4'($urandom);
         rg = 4'($urandom_range(0, 6));
         issue(rp, rr, rg);
         wait_done(1, 0);
         if ($urandom_range(0, 3) != 0) begin
            check_drained("random");
            @(negedge clk);
         end
      end
      check_drained("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
